proj_extender_sched: RTL and testbench

Batch scheduler and stream controller for the fragment extender stage. Accepts one batch per handshake from the sorter: a fragment plus up to INDICES_COUNT k-mer indices. For each valid index it emits FRAG_PARTS_COUNT beats, each carrying the signed extended start index and one FRAG_PART-wide slice of the fragment. The output is a valid/ready stream with backpressure, first/last markers and optional dropping of negative start indices. It sits between the sorter and the GFM/matching stage.

---
 rtl/proj_extender_sched.sv | 155 +++++++++++++++
 tb/tb_proj_extender_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_extender_sched.sv
// proj_extender_sched: batch scheduler for the fragment extender stage.
// Takes one batch (fragment + up to INDICES_COUNT k-mer indices) per
// handshake and streams FRAG_PARTS_COUNT beats per valid index, each carrying
// the signed extended start index and one FRAG_PART-wide fragment slice.

package proj_pkg;
    parameter int FM_EXTENDER_FRAG_LEN_BITS     = 64;
    parameter int FRAG_LEN                      = 32;
    parameter int KMER_LEN                      = 16;
    parameter int SORTER_EXTENDER_INDICES_COUNT = 4;
    parameter int INDICE_LEN                    = 8;
    parameter int SIGNED_INDICE_LEN             = 9;
    parameter int EXTENDER_OUT_PART_LEN         = 16;
endpackage

module proj_extender_sched #(
    parameter int FRAG_LEN_BITS     = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
    parameter int FRAG_SIZE         = proj_pkg::FRAG_LEN,
    parameter int KMER_SIZE         = proj_pkg::KMER_LEN,
    parameter int INDICES_COUNT     = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
    parameter int INDICE_LEN        = proj_pkg::INDICE_LEN,
    parameter int SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
    parameter int FRAG_PART         = proj_pkg::EXTENDER_OUT_PART_LEN,
    parameter bit DROP_NEG          = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FRAG_LEN_BITS-1:0]            in_fragment,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_kmer_indices,
    input  logic [$clog2(INDICES_COUNT):0]      in_count,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SIGNED_INDICE_LEN-1:0]        out_index,
    output logic [FRAG_PART-1:0]                out_gfm,
    output logic                                out_first,
    output logic                                out_last,
    output logic                                batch_done
);

    localparam int FRAG_PARTS_COUNT = FRAG_LEN_BITS / FRAG_PART;
    localparam int OFFSET           = (FRAG_SIZE - KMER_SIZE) >> 1;
    localparam int CW               = $clog2(INDICES_COUNT) + 1;
    localparam int SW               = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam int PW               = (FRAG_PARTS_COUNT > 1) ? $clog2(FRAG_PARTS_COUNT) : 1;

    localparam logic [SIGNED_INDICE_LEN-1:0] OFFSET_S  = SIGNED_INDICE_LEN'(OFFSET);
    localparam logic [CW-1:0]                IC_C      = CW'(INDICES_COUNT);
    localparam logic [PW-1:0]                PART_LAST = PW'(FRAG_PARTS_COUNT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    logic [FRAG_LEN_BITS-1:0] r_frag;
    logic [INDICE_LEN-1:0]  r_idx [INDICES_COUNT];
    logic [CW-1:0]          r_cnt;
    logic [SW-1:0]          r_slot;
    logic [PW-1:0]          r_part_idx;
    logic                   r_batch_done;

    logic [INDICE_LEN-1:0]  w_cur_idx;
    logic                   w_streaming;
    logic                   w_skip;
    logic                   w_last_slot;
    logic                   w_last_part;
    logic [CW-1:0]          w_in_cnt;
    logic [FRAG_PART-1:0]   w_parts [FRAG_PARTS_COUNT];

    assign w_cur_idx   = r_idx[r_slot];
    assign w_streaming = (r_state == ST_STREAM);
    // Indices whose extended start would fall before the fragment are skipped
    // only when DROP_NEG is set; the compare is done in the widened domain.
    assign w_skip      = DROP_NEG && ({1'b0, w_cur_idx} < OFFSET_S);
    assign w_last_slot = ({1'b0, r_slot} == (r_cnt - CW'(1)));
    assign w_last_part = (r_part_idx == PART_LAST);
    // Oversized counts from the sorter are clamped to the slot capacity.
    assign w_in_cnt    = (in_count > IC_C) ? IC_C : in_count;

    // Split the held fragment into output slices, part 0 at the LSBs.
    always_comb begin
        for (int p = 0; p < FRAG_PARTS_COUNT; p++) begin
            w_parts[p] = r_frag[p*FRAG_PART +: FRAG_PART];
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = w_streaming && !w_skip;
    assign out_gfm    = w_parts[r_part_idx];
    assign out_index  = {1'b0, w_cur_idx} - OFFSET_S;
    assign out_first  = (r_part_idx == PW'(0));
    assign out_last   = w_streaming && w_last_part && w_last_slot;
    assign batch_done = r_batch_done;

    // Scheduler FSM: batch capture, slot/part sequencing and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_frag       <= '0;
            r_cnt        <= '0;
            r_slot       <= '0;
            r_part_idx   <= '0;
            r_batch_done <= 1'b0;
            for (int i = 0; i < INDICES_COUNT; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_batch_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_frag     <= in_fragment;
                        r_cnt      <= w_in_cnt;
                        r_slot     <= '0;
                        r_part_idx <= '0;
                        for (int i = 0; i < INDICES_COUNT; i++) begin
                            r_idx[i] <= in_kmer_indices[i*INDICE_LEN +: INDICE_LEN];
                        end
                        if (w_in_cnt == CW'(0)) begin
                            r_batch_done <= 1'b1;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (w_skip || (out_ready && w_last_part)) begin
                        // Slot finished, either dropped in one cycle or after its final part.
                        r_part_idx <= '0;
                        if (w_last_slot) begin
                            r_slot       <= '0;
                            r_state      <= ST_IDLE;
                            r_batch_done <= 1'b1;
                        end else begin
                            r_slot <= r_slot + SW'(1);
                        end
                    end else if (out_ready) begin
                        r_part_idx <= r_part_idx + PW'(1);
                    end else begin
                        r_part_idx <= r_part_idx;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proj_extender_sched.sv
// Bench for proj_extender_sched: one instance without and one with DROP_NEG,
// checked beat-by-beat against a list of beats built from the index arithmetic.
module tb_proj_extender_sched;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_fragment;
    logic [31:0] in_kmer_indices;
    logic [2:0]  in_count;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  out_first, out_last, batch_done;
    logic [8:0]  out_index [2];
    logic [15:0] out_gfm   [2];

    int n_checks = 0;
    int n_err    = 0;
    logic [63:0] exp_q[$];
    int exp_cycles;

    localparam logic [63:0] FRAG = 64'h4444_3333_2222_1111;

    proj_extender_sched #(.DROP_NEG(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_fragment(in_fragment), .in_kmer_indices(in_kmer_indices), .in_count(in_count),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_index(out_index[0]), .out_gfm(out_gfm[0]),
        .out_first(out_first[0]), .out_last(out_last[0]), .batch_done(batch_done[0])
    );

    proj_extender_sched #(.DROP_NEG(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_fragment(in_fragment), .in_kmer_indices(in_kmer_indices), .in_count(in_count),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_index(out_index[1]), .out_gfm(out_gfm[1]),
        .out_first(out_first[1]), .out_last(out_last[1]), .batch_done(batch_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] act_beat(input int d);
        return {37'd0, out_first[d], out_last[d], out_index[d], out_gfm[d]};
    endfunction

    // Reference: list every beat the batch should produce, plus the cycle cost at full rate.
    task automatic build_exp(input logic [63:0] frag, input logic [31:0] idxs,
                             input int count, input bit drop);
        int c;
        int v;
        int si;
        logic [8:0]  ix;
        logic [15:0] g;
        exp_q.delete();
        exp_cycles = 0;
        c = (count > 4) ? 4 : count;
        for (int s = 0; s < c; s++) begin
            v  = int'(idxs[s*8 +: 8]);
            si = v - 8;
            if (drop && si < 0) begin
                exp_cycles += 1;
            end else begin
                ix = 9'(si);
                for (int p = 0; p < 4; p++) begin
                    g = 16'((frag >> (16 * p)) & 64'hFFFF);
                    exp_q.push_back({37'd0, (p == 0), (p == 3 && s == c - 1), ix, g});
                    exp_cycles += 1;
                end
            end
        end
    endtask

    task automatic offer(input int d, input logic [63:0] frag, input logic [31:0] idxs,
                         input logic [2:0] count, input bit hold);
        @(negedge clk);
        in_fragment     = frag;
        in_kmer_indices = idxs;
        in_count        = count;
        in_valid[d]     = 1'b1;
        check_val("in_ready_at_offer", {63'd0, in_ready[d]}, 64'd1);
        @(posedge clk);
        if (!hold) begin
            #1;
            in_valid[d] = 1'b0;
        end
    endtask

    task automatic collect(input int d, input bit bp);
        int k = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit held = 1'b0;
        logic [63:0] held_v = 64'd0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (batch_done[d]) begin
                done = 1'b1;
                break;
            end
            out_ready[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
            if (held) begin
                check_val("hold_valid", {63'd0, out_valid[d]}, 64'd1);
                if (out_valid[d]) check_val("hold_data", act_beat(d), held_v);
            end
            if (out_valid[d]) begin
                if (out_ready[d]) begin
                    if (k < exp_q.size()) check_val("beat", act_beat(d), exp_q[k]);
                    else check_val("extra_beat", {63'd0, out_valid[d]}, 64'd0);
                    k++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_v = act_beat(d);
                end
            end
        end
        check_val("done_seen", {63'd0, done}, 64'd1);
        check_val("done_in_ready", {63'd0, in_ready[d]}, 64'd1);
        check_val("done_no_valid", {63'd0, out_valid[d]}, 64'd0);
        check_val("beat_count", 64'(k), 64'(exp_q.size()));
        if (!bp) check_val("cycles", 64'(cyc), 64'(exp_cycles));
        out_ready[d] = 1'b1;
    endtask

    task automatic run(input int d, input logic [63:0] frag, input logic [31:0] idxs,
                       input logic [2:0] count, input bit bp);
        build_exp(frag, idxs, int'(count), (d == 1));
        offer(d, frag, idxs, count, 1'b0);
        collect(d, bp);
    endtask

    initial begin
        logic [31:0] ridx;
        logic [63:0] rfrag;
        rst_n           = 1'b0;
        in_valid        = 2'b00;
        out_ready       = 2'b11;
        in_fragment     = FRAG;
        in_kmer_indices = 32'h1E09_1408;
        in_count        = 3'd4;

        // Reset values, and a batch offered while in reset must be ignored.
        #1;
        check_val("rst_valid", {63'd0, out_valid[0]}, 64'd0);
        check_val("rst_ready", {63'd0, in_ready[0]}, 64'd1);
        check_val("rst_done",  {63'd0, batch_done[0]}, 64'd0);
        check_val("rst_last",  {63'd0, out_last[0]}, 64'd0);
        check_val("rst_first", {63'd0, out_first[0]}, 64'd1);
        check_val("rst_index", {55'd0, out_index[0]}, 64'h1F8);
        check_val("rst_gfm",   {48'd0, out_gfm[0]}, 64'd0);
        in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_val("post_rst_idle", {62'd0, out_valid[0], batch_done[0]}, 64'd0);
        end

        // Full batch at full rate, then with random backpressure.
        run(0, FRAG, 32'h1E09_1408, 3'd4, 1'b0);
        run(0, FRAG, 32'h1E09_1408, 3'd4, 1'b1);

        // Negative start: kept without DROP_NEG, dropped with it.
        run(0, FRAG, 32'h0000_0003, 3'd1, 1'b0);
        run(1, FRAG, 32'h0000_0A03, 3'd2, 1'b0);

        // Count edge cases.
        run(0, FRAG, 32'h1E09_1408, 3'd0, 1'b0);
        run(0, FRAG, 32'h1E09_1408, 3'd6, 1'b0);

        // Back-to-back batches with in_valid held high.
        build_exp(FRAG, 32'h0B0C_0D0E, 4, 1'b1);
        offer(1, FRAG, 32'h0B0C_0D0E, 3'd4, 1'b1);
        #1;
        in_fragment     = 64'h8888_7777_6666_5555;
        in_kmer_indices = 32'h0000_2010;
        in_count        = 3'd2;
        collect(1, 1'b0);
        check_val("b2b_valid_held", {63'd0, in_valid[1]}, 64'd1);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        build_exp(64'h8888_7777_6666_5555, 32'h0000_2010, 2, 1'b1);
        collect(1, 1'b0);

        // Mid-stream reset after six beats.
        build_exp(FRAG, 32'h1E09_1408, 4, 1'b0);
        offer(0, FRAG, 32'h1E09_1408, 3'd4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("pre_rst_beat", act_beat(0), exp_q[i]);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid", {63'd0, out_valid[0]}, 64'd0);
        check_val("midrst_ready", {63'd0, in_ready[0]}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("after_rst", {61'd0, out_valid[0], batch_done[0], in_ready[0]}, 64'd1);
        end
        run(0, FRAG, 32'h1E09_1408, 3'd4, 1'b0);

        // Randomized batches on both instances.
        for (int n = 0; n < 24; n++) begin
            ridx = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) ridx[b*8 +: 8] = 8'($urandom_range(0, 15));
            end
            rfrag = {$urandom, $urandom};
            run(int'($urandom_range(0, 1)), rfrag, ridx, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
